// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcode values, FSM state encodings and the opcode legality check
// used by the command sequencer and anything that decodes its opcode output.
package alu_cmd_sequencer_pkg;

    localparam int BITS_DATA_DEF = 8;
    localparam int BITS_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_GET_OP = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;

    // Opcode field is zero-extended so callers with any BITS_OP share one check
    function automatic logic op_is_legal(input logic [31:0] op);
        logic legal;
        case (op)
            32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
            32'(OP_XOR), 32'(OP_SRA), 32'(OP_SRL), 32'(OP_NOR): legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags the cycle in which
// the count reaches TIMEOUT-1.
module cmd_timeout_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;
    logic          expire_s;

    // Expiry is qualified by enable so a transfer in the same cycle suppresses it
    always_comb begin
        expire_s = enable && (cnt_r == CNT_LAST);
    end

    assign expire = expire_s;

    // Idle cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear || expire_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the ALU: collects A, B and OP bytes, drives the
// ALU operand registers, waits out the ALU latency and returns one result byte.
module alu_cmd_sequencer #(
    parameter int BITS_DATA = 8,
    parameter int BITS_OP   = 6,
    parameter int ALU_LAT   = 1,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [BITS_DATA-1:0] i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [BITS_DATA-1:0] o_alu_a,
    output logic [BITS_DATA-1:0] o_alu_b,
    output logic [BITS_OP-1:0]   o_alu_op,
    input  logic [BITS_DATA-1:0] i_alu_result,
    output logic [BITS_DATA-1:0] o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_error
);

    import alu_cmd_sequencer_pkg::*;

    // The result is sampled ALU_LAT+1 edges after the OP byte edge, so the
    // EXEC counter runs from 0 up to ALU_LAT inclusive.
    localparam int LW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT);

    logic [2:0]           state_r;
    logic [2:0]           state_next_s;
    logic [BITS_DATA-1:0] a_r;
    logic [BITS_DATA-1:0] b_r;
    logic [BITS_OP-1:0]   op_r;
    logic [BITS_DATA-1:0] tx_data_r;
    logic                 tx_valid_r;
    logic                 error_r;
    logic                 busy_r;
    logic                 rx_ready_r;
    logic [LW-1:0]        lat_cnt_r;

    logic xfer_s;
    logic op_legal_s;
    logic take_a_s;
    logic take_b_s;
    logic take_op_s;
    logic load_tx_s;
    logic done_tx_s;
    logic err_s;
    logic wait_byte_s;
    logic timer_clear_s;
    logic expire_s;

    // Transfer qualification, opcode legality and idle-timer control
    always_comb begin
        xfer_s        = i_rx_valid && rx_ready_r;
        op_legal_s    = op_is_legal(32'(i_rx_data[BITS_OP-1:0])) &&
                        ((i_rx_data >> BITS_OP) == {BITS_DATA{1'b0}});
        wait_byte_s   = (state_r == ST_GET_B) || (state_r == ST_GET_OP);
        timer_clear_s = xfer_s || !wait_byte_s;
    end

    cmd_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (i_reset),
        .clear  (timer_clear_s),
        .enable (wait_byte_s && !xfer_s),
        .expire (expire_s)
    );

    // Next-state and per-cycle action decode; a transfer always beats expiry
    always_comb begin
        state_next_s = state_r;
        take_a_s     = 1'b0;
        take_b_s     = 1'b0;
        take_op_s    = 1'b0;
        load_tx_s    = 1'b0;
        done_tx_s    = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_GET_A: begin
                if (xfer_s) begin
                    take_a_s     = 1'b1;
                    state_next_s = ST_GET_B;
                end else begin
                    state_next_s = ST_GET_A;
                end
            end
            ST_GET_B: begin
                if (xfer_s) begin
                    take_b_s     = 1'b1;
                    state_next_s = ST_GET_OP;
                end else if (expire_s) begin
                    err_s        = 1'b1;
                    state_next_s = ST_GET_A;
                end else begin
                    state_next_s = ST_GET_B;
                end
            end
            ST_GET_OP: begin
                if (xfer_s && op_legal_s) begin
                    take_op_s    = 1'b1;
                    state_next_s = ST_EXEC;
                end else if (xfer_s) begin
                    err_s        = 1'b1;
                    state_next_s = ST_GET_A;
                end else if (expire_s) begin
                    err_s        = 1'b1;
                    state_next_s = ST_GET_A;
                end else begin
                    state_next_s = ST_GET_OP;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_r == LAT_LAST) begin
                    load_tx_s    = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    done_tx_s    = 1'b1;
                    state_next_s = ST_GET_A;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                state_next_s = ST_GET_A;
            end
        endcase
    end

    // State, operand/result registers and registered status outputs
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r    <= ST_GET_A;
            a_r        <= {BITS_DATA{1'b0}};
            b_r        <= {BITS_DATA{1'b0}};
            op_r       <= {BITS_OP{1'b0}};
            tx_data_r  <= {BITS_DATA{1'b0}};
            tx_valid_r <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b1;
            lat_cnt_r  <= {LW{1'b0}};
        end else begin
            state_r    <= state_next_s;
            error_r    <= err_s;
            busy_r     <= (state_next_s != ST_GET_A);
            rx_ready_r <= (state_next_s == ST_GET_A) || (state_next_s == ST_GET_B) ||
                          (state_next_s == ST_GET_OP);
            if (take_a_s) begin
                a_r <= i_rx_data;
            end else begin
                a_r <= a_r;
            end
            if (take_b_s) begin
                b_r <= i_rx_data;
            end else begin
                b_r <= b_r;
            end
            if (take_op_s) begin
                op_r      <= i_rx_data[BITS_OP-1:0];
                lat_cnt_r <= {LW{1'b0}};
            end else if ((state_r == ST_EXEC) && !load_tx_s) begin
                op_r      <= op_r;
                lat_cnt_r <= lat_cnt_r + 1'b1;
            end else begin
                op_r      <= op_r;
                lat_cnt_r <= lat_cnt_r;
            end
            if (load_tx_s) begin
                tx_data_r  <= i_alu_result;
                tx_valid_r <= 1'b1;
            end else if (done_tx_s) begin
                tx_data_r  <= tx_data_r;
                tx_valid_r <= 1'b0;
            end else begin
                tx_data_r  <= tx_data_r;
                tx_valid_r <= tx_valid_r;
            end
        end
    end

    assign o_rx_ready = rx_ready_r;
    assign o_alu_a    = a_r;
    assign o_alu_b    = b_r;
    assign o_alu_op   = op_r;
    assign o_tx_data  = tx_data_r;
    assign o_tx_valid = tx_valid_r;
    assign o_busy     = busy_r;
    assign o_error    = error_r;

endmodule
